// File: rtl/seg7_hex_scan_if.sv
// Display-side bus of seg7_hex_scan: value/load/hold in, scanned digit drive out.
// The master is whatever feeds the count and reads the pins; the slave is the scanner.
interface seg7_hex_scan_if;
  logic [31:0] value;
  logic        load;
  logic        hold;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  modport master (
    output value, load, hold,
    input  an, seg, frame_done
  );

  modport slave (
    input  value, load, hold,
    output an, seg, frame_done
  );
endinterface

// File: rtl/seg7_hex_scan.sv
// Scans a 32-bit count onto an 8-digit common-anode hex display, swapping the shown
// value only on frame boundaries so one frame never mixes two counts.
module seg7_hex_scan #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  seg7_hex_scan_if.slave  bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

  logic [31:0]   r_shadow;
  logic [31:0]   r_pendVal;
  logic          r_pend;
  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [7:0]    r_an;
  logic [7:0]    r_seg;
  logic          r_frameDone;

  logic          w_tick;
  logic          w_wrap;
  logic          w_accept;
  logic [31:0]   w_upper;
  logic          w_blank;
  logic [6:0]    w_dec;

  assign w_tick   = (r_presc == LAST);
  assign w_wrap   = w_tick && (r_idx == 3'd7);
  assign w_accept = bus.load && !bus.hold;

  // Shifting the current digit down to bit 0 gives both its nibble and the
  // "everything from here up is zero" test used for leading-zero blanking.
  assign w_upper  = r_shadow >> {r_idx, 2'b00};
  assign w_blank  = LZ_BLANK && (r_idx != 3'd0) && (w_upper == 32'd0);

  always_comb begin
    w_dec = 7'h7F;
    case (w_upper[3:0])
      4'h0: w_dec = 7'h40;
      4'h1: w_dec = 7'h79;
      4'h2: w_dec = 7'h24;
      4'h3: w_dec = 7'h30;
      4'h4: w_dec = 7'h19;
      4'h5: w_dec = 7'h12;
      4'h6: w_dec = 7'h02;
      4'h7: w_dec = 7'h78;
      4'h8: w_dec = 7'h00;
      4'h9: w_dec = 7'h10;
      4'hA: w_dec = 7'h08;
      4'hB: w_dec = 7'h03;
      4'hC: w_dec = 7'h46;
      4'hD: w_dec = 7'h21;
      4'hE: w_dec = 7'h06;
      4'hF: w_dec = 7'h0E;
      default: w_dec = 7'h7F;
    endcase
  end

  // A load landing exactly on the wrap bypasses the pending slot so the newest value wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow    <= 32'd0;
      r_pendVal   <= 32'd0;
      r_pend      <= 1'b0;
      r_presc     <= '0;
      r_idx       <= 3'd0;
      r_an        <= 8'hFF;
      r_seg       <= 8'hFF;
      r_frameDone <= 1'b0;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= r_idx + 3'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      r_frameDone <= w_wrap;

      if (w_accept) begin
        if (w_wrap) begin
          r_shadow <= bus.value;
          r_pend   <= 1'b0;
        end else begin
          r_pendVal <= bus.value;
          r_pend    <= 1'b1;
        end
      end else if (w_wrap && r_pend) begin
        r_shadow <= r_pendVal;
        r_pend   <= 1'b0;
      end

      r_an  <= ~(8'b1 << r_idx);
      r_seg <= w_blank ? 8'hFF : {1'b1, w_dec};
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.frame_done = r_frameDone;

endmodule

// File: tb/tb_seg7_hex_scan.sv
// Directed bench for seg7_hex_scan: a frame-level model pushes the expected pins for
// every clock into a queue, and each sample after the edge pops and checks them.
module tb_seg7_hex_scan;

  localparam int SCAN_DIV = 4;
  localparam int FRAME    = 8 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rstIn;
  logic [31:0] valueIn;
  logic        loadIn;
  logic        holdIn;

  always #5 clk = ~clk;

  seg7_hex_scan_if busLz ();
  seg7_hex_scan_if busAll ();

  assign busLz.value  = valueIn;
  assign busLz.load   = loadIn;
  assign busLz.hold   = holdIn;
  assign busAll.value = valueIn;
  assign busAll.load  = loadIn;
  assign busAll.hold  = holdIn;

  seg7_hex_scan #(.SCAN_DIV(SCAN_DIV), .LZ_BLANK(1'b1)) dut (
    .clk (clk),
    .rst (rstIn),
    .bus (busLz)
  );

  seg7_hex_scan #(.SCAN_DIV(SCAN_DIV), .LZ_BLANK(1'b0)) dutAll (
    .clk (clk),
    .rst (rstIn),
    .bus (busAll)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] segLz;
    logic [7:0] segAll;
    logic       fd;
  } expT;

  expT         expQ[$];
  int          checks   = 0;
  int          failures = 0;
  int          k        = 0;
  logic [31:0] dispVal  = 32'd0;
  logic [31:0] latestVal = 32'd0;

  function automatic logic [7:0] hexSeg(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // Digits above the most significant non-zero nibble are blank; digit 0 always shows.
  function automatic logic [7:0] expSeg(input logic [31:0] v, input int d, input bit lz);
    int top;
    top = 0;
    for (int i = 0; i < 8; i++)
      if (v[4*i +: 4] != 4'h0) top = i;
    if (lz && d > top) return 8'hFF;
    return hexSeg(v[4*d +: 4]);
  endfunction

  task automatic checkOutput();
    expT e;
    e = expQ.pop_front();
    checks++;
    assert (busLz.an === e.an) else begin
      failures++;
      $error("[TB] FAIL an k=%0d observed=%h expected=%h", k, busLz.an, e.an);
    end
    checks++;
    assert (busLz.seg === e.segLz) else begin
      failures++;
      $error("[TB] FAIL seg_lz k=%0d observed=%h expected=%h", k, busLz.seg, e.segLz);
    end
    checks++;
    assert (busAll.seg === e.segAll) else begin
      failures++;
      $error("[TB] FAIL seg_all k=%0d observed=%h expected=%h", k, busAll.seg, e.segAll);
    end
    checks++;
    assert (busLz.frame_done === e.fd && busAll.frame_done === e.fd) else begin
      failures++;
      $error("[TB] FAIL frame_done k=%0d observed=%b/%b expected=%b",
             k, busLz.frame_done, busAll.frame_done, e.fd);
    end
    checks++;
    assert (busAll.an === e.an) else begin
      failures++;
      $error("[TB] FAIL an_all k=%0d observed=%h expected=%h", k, busAll.an, e.an);
    end
  endtask

  // One clock: drive inputs, push what the pins must show after the edge, then check.
  task automatic applyStimulus(input logic r, input logic ld, input logic [31:0] v);
    int  d;
    expT e;
    @(negedge clk);
    rstIn   = r;
    loadIn  = ld;
    valueIn = v;
    if (r) begin
      e = '{an: 8'hFF, segLz: 8'hFF, segAll: 8'hFF, fd: 1'b0};
      k = 0;
      dispVal = 32'd0;
      latestVal = 32'd0;
    end else begin
      k++;
      d = ((k - 1) / SCAN_DIV) % 8;
      e.an     = ~(8'b1 << d);
      e.segLz  = expSeg(dispVal, d, 1'b1);
      e.segAll = expSeg(dispVal, d, 1'b0);
      e.fd     = ((k % FRAME) == 0);
      if (ld && !holdIn) latestVal = v;
      if ((k % FRAME) == 0) dispVal = latestVal;
    end
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idleTo(input int target);
    while (k < target) applyStimulus(1'b0, 1'b0, $urandom);
  endtask

  task automatic loadAt(input int target, input logic [31:0] v);
    idleTo(target - 1);
    applyStimulus(1'b0, 1'b1, v);
  endtask

  initial begin
    rstIn   = 1'b1;
    loadIn  = 1'b0;
    holdIn  = 1'b0;
    valueIn = 32'd0;

    repeat (3) applyStimulus(1'b1, 1'b0, 32'd0);
    idleTo(2 * FRAME);

    loadAt(75, 32'h0000ABCD);
    idleTo(4 * FRAME);

    loadAt(135, 32'h11111111);
    loadAt(150, 32'h89ABCDEF);
    idleTo(6 * FRAME);

    loadAt(200, 32'hAAAA5555);
    loadAt(7 * FRAME, 32'h12345678);
    idleTo(8 * FRAME);

    loadAt(270, 32'h00C0FFEE);
    holdIn = 1'b1;
    loadAt(275, 32'hFFFFFFFF);
    loadAt(300, 32'hFFFFFFFF);
    loadAt(10 * FRAME, 32'hFFFFFFFF);
    idleTo(12 * FRAME);
    holdIn = 1'b0;
    loadAt(390, 32'hFFFFFFFF);
    idleTo(14 * FRAME);

    loadAt(460, 32'h00000005);
    idleTo(16 * FRAME);

    loadAt(520, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b1, 32'h0BADF00D);
    idleTo(2 * FRAME + 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_hex_scan.md
Name: seg7_hex_scan

Overview:
- Downstream consumer of the free-running 32-bit cycle counter.
- Shows the count as 8 hex digits on the board's multiplexed, common-anode 7-segment display.
- Takes a new value only at frame boundaries, so a displayed frame never mixes two counts.
- Supports hold (freeze), optional leading-zero blanking, and a per-frame done pulse.

Parameters:
- SCAN_DIV, 100000, clk cycles each digit stays lit; legal range 1..2^20.
- LZ_BLANK, 1, 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all digits.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- value  in  32  count to display.
- load  in  1  capture strobe for value.
- hold  in  1  1 = ignore load (display frozen).
- an  out  8  digit enables, active-low; bit k = digit k (digit 0 = least significant nibble).
- seg  out  8  active-low {dp,g,f,e,d,c,b,a}.
- frame_done  out  1  one-cycle pulse when digit 7's slot ends.

Behaviour:
- Internal state: shadow[31:0] (value being shown), pend_val[31:0], pend flag, prescaler (0..SCAN_DIV-1), idx[2:0].
- Reset (sampled on posedge): shadow=0, pend_val=0, pend=0, prescaler=0, idx=0, an=8'hFF, seg=8'hFF, frame_done=0. rst overrides all other inputs, including a load in the same cycle.
- tick = (prescaler==SCAN_DIV-1). On tick: prescaler<=0, idx<=idx+1 (7 wraps to 0). Otherwise prescaler<=prescaler+1.
- wrap = tick && idx==7. frame_done<=wrap, so the pulse is visible the cycle after wrap, aligned with idx returning to 0.
- Capture, when load && !hold:
  - Not wrap: pend_val<=value, pend<=1. The latest load before the boundary wins.
  - Wrap in the same cycle: shadow<=value directly and pend<=0 (bypass; the newest value wins over pend_val).
- Commit: on wrap with no accepted load that cycle and pend=1: shadow<=pend_val, pend<=0.
- hold=1: load is ignored. An already-pending value still commits at the next wrap. Scanning continues.
- Output registers, updated every non-reset cycle from the current idx and shadow (one-cycle latency):
  - an<=~(8'b1<<idx).
  - nib=shadow[4*idx+3 -: 4].
  - Blank when LZ_BLANK && idx!=0 && shadow[31:4*idx]==0, then seg<=8'hFF. Otherwise seg<={1'b1, decode(nib)}; dp is always off.
- Decode (7 bits g..a, active-low), 0-F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E. Full seg bytes 0-F: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
- Frame period = 8*SCAN_DIV cycles. SCAN_DIV=1: idx advances every cycle and wrap occurs every 8 cycles.
- Prescaler wrap-around is exact; no glitch on idx 7->0.
- Reset mid-frame: outputs go all-off the next cycle, the pending value is discarded, and scanning restarts at digit 0.

Test Plan (bench uses SCAN_DIV=4):
- Reset release:
  - Cycle 1 after rst drop: an=FE, seg=C0.
  - Then each digit is lit 4 cycles in order FE,FD,FB,...,7F.
  - Digits 1-7: seg=FF (LZ_BLANK=1).
  - frame_done pulses once every 32 cycles.
- load value=32'h0000ABCD mid-frame:
  - The current frame continues to show 0.
  - From the next frame: digits 0-3 show C6? no: digit0=A1(d), digit1=C6(C), digit2=83(b), digit3=88(A); digits 4-7 show FF.
- Two loads in one frame (32'h11111111, then 32'h89ABCDEF): the next frame shows only 89ABCDEF. Digit 7=80, digit 0=8E.
- load with value=32'h12345678 in the exact wrap cycle: that value is shown in the frame starting next cycle; the older pend_val is discarded.
- hold=1 with load pulsed with 32'hFFFFFFFF: the display is unchanged across 3 frames. Then hold=0 and load again: the next frame shows 8E on all 8 digits.
- LZ_BLANK=0 with value 32'h00000005 loaded: digit0=92, digits 1-7=C0.
- Reset mid-frame:
  - Assert rst with pend=1, for 1 cycle, alongside a load: the next cycle has an=FF, seg=FF.
  - After release, digit 0 shows C0 and the pending value never appears.
